// File: rtl/disk_burst_model.sv
// ---------------------------------------------------------------------------
// disk_burst_model
//
// Behavioural disk model for the DMA-disk interface. It accepts a DMA
// command (start word address, word count, direction) and waits out a fixed
// seek latency. It then streams a burst of words with per-word valid/ready
// handshakes. When the burst ends it holds a completion flag until the DMA
// acknowledges it.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   d_init       command strobe (only honoured in IDLE)
//   d_wr         command direction (1 = write to disk, 0 = read from disk)
//   d_addr       burst start word address
//   d_len        burst word count (0 is illegal)
//   d_done       completion acknowledge in DONE, abort in SEEK/XFER
//   d_busy       high while seeking or transferring
//   d_valid      read word valid
//   d_data       read word (0 when d_valid is low)
//   d_accept     DMA takes the current read word
//   d_wready     model accepts a write word
//   d_wvalid     DMA write word valid
//   d_wdata      write word
//   d_ready      burst complete, held until d_done
//   d_err        one-cycle pulse after an illegal or ignored command
//
// Optional feature (macro DISK_PATTERN_INIT_EN):
//   When defined, every accepted read command first fills the whole storage
//   with PAT_BASE + address (truncated to DATA_W). When undefined, storage
//   holds only what has been written, and the PAT_BASE parameter is absent.
// ---------------------------------------------------------------------------
module disk_burst_model #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 8,
    parameter int LAT_CYC = 108
`ifdef DISK_PATTERN_INIT_EN
    ,
    parameter logic [31:0] PAT_BASE = 32'hD15C_0000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_init,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LEN_W-1:0]  d_len,
    input  logic              d_done,
    output logic              d_busy,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_data,
    input  logic              d_accept,
    output logic              d_wready,
    input  logic              d_wvalid,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(LAT_CYC + 1);

    typedef enum logic [1:0] {IDLE, SEEK, XFER, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  rem;
    logic [CNT_W-1:0]  seek_cnt;
    logic              dir;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic cmd_ok;
    logic rd_beat;
    logic wr_beat;
    logic beat;
    logic seek_end;

    always_comb begin
        cmd_ok   = (state == IDLE) && d_init && (d_len != '0);
        rd_beat  = (state == XFER) && !dir && d_accept;
        wr_beat  = (state == XFER) && dir && d_wvalid;
        beat     = rd_beat || wr_beat;
        seek_end = (seek_cnt == CNT_W'(LAT_CYC));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // An abort (d_done) in SEEK or XFER takes priority over the normal
    // transitions. A beat that handshakes in the abort cycle still completes.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (cmd_ok) next_state = SEEK;
            SEEK: begin
                if (d_done)        next_state = IDLE;
                else if (seek_end) next_state = XFER;
            end
            XFER: begin
                if (d_done)                            next_state = IDLE;
                else if (beat && rem == LEN_W'(1))     next_state = DONE;
            end
            DONE: if (d_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The seek counter starts at 1 on the command edge. The SEEK->XFER edge
    // therefore lands exactly LAT_CYC cycles after d_init is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            rem      <= '0;
            seek_cnt <= '0;
            dir      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= d_init && ((state != IDLE) || (d_len == '0));
            if (cmd_ok) begin
                ptr      <= d_addr;
                rem      <= d_len;
                dir      <= d_wr;
                seek_cnt <= CNT_W'(1);
            end else begin
                if (state == SEEK && !seek_end) begin
                    seek_cnt <= seek_cnt + CNT_W'(1);
                end
                if (beat) begin
                    ptr <= ptr + ADDR_W'(1);
                    rem <= rem - LEN_W'(1);
                end
            end
        end
    end

    // Storage is deliberately not reset, so its contents survive a reset.
    always_ff @(posedge clk) begin
`ifdef DISK_PATTERN_INIT_EN
        if (cmd_ok && !d_wr) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= DATA_W'(PAT_BASE + 32'(a));
            end
        end
`endif
        if (wr_beat) begin
            mem[ptr] <= d_wdata;
        end
    end

    always_comb begin
        d_busy   = (state == SEEK) || (state == XFER);
        d_valid  = (state == XFER) && !dir;
        d_wready = (state == XFER) && dir;
        d_ready  = (state == DONE);
        d_err    = err_q;
        d_data   = ((state == XFER) && !dir) ? mem[ptr] : '0;
    end

endmodule

// File: doc/disk_burst_model.md
Name: disk_burst_model

Overview:
Parametrised behavioural disk model with configurable data/address width and access latency. Accepts a DMA command carrying start address, word count and direction, then models seek latency. Streams a multi-word burst in either direction with per-word valid/ready handshakes, then holds a completion flag until the DMA acknowledges. Sits on the DMA-disk interface; read-back data is deterministic so the bench can check it.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 10, word address width; storage depth = 2^ADDR_W words
LEN_W, 8, burst length field width
LAT_CYC, 108, seek latency in clk cycles (750 ns / 7 ns); must be >= 1
PAT_BASE, 32'hD15C_0000, base value for the pattern fill (optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
d_init  in  1  command strobe, sampled in IDLE only
d_wr  in  1  command direction: 1 = write to disk, 0 = read from disk
d_addr  in  ADDR_W  burst start word address, sampled with d_init
d_len  in  LEN_W  burst word count, sampled with d_init; 0 is illegal
d_done  in  1  DMA completion acknowledge / abort
d_busy  out  1  high in SEEK and XFER
d_valid  out  1  read data valid (XFER, read)
d_data  out  DATA_W  read data = mem[ptr] when d_valid, else 0
d_accept  in  1  DMA takes the current read word
d_wready  out  1  model accepts a write word (XFER, write)
d_wvalid  in  1  DMA write word valid
d_wdata  in  DATA_W  write data
d_ready  out  1  burst complete, held until d_done
d_err  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: state IDLE, and all of d_busy, d_valid, d_wready, d_ready, d_err and d_data are 0. Internal ptr, remaining count and seek counter are 0. Storage is not reset.
- States are IDLE, SEEK, XFER and DONE.
- IDLE:
  - d_init with d_len != 0: latch ptr = d_addr, rem = d_len, dir = d_wr; seek counter = 1; go to SEEK.
  - d_init with d_len == 0: d_err pulses for 1 cycle; stay in IDLE.
- SEEK:
  - Counter increments each cycle.
  - At the edge where counter == LAT_CYC, go to XFER.
  - Result: first d_valid/d_wready is high exactly LAT_CYC cycles after the d_init sampling edge.
- XFER, read direction:
  - d_valid = 1 and d_data = mem[ptr] (combinational).
  - On d_valid & d_accept: ptr++ and rem--.
  - If rem was 1, go to DONE.
  - Sustains 1 word/cycle.
- XFER, write direction:
  - d_wready = 1.
  - On d_wvalid: mem[ptr] <= d_wdata, ptr++, rem--.
  - If rem was 1, go to DONE.
- ptr wraps modulo 2^ADDR_W; a burst crossing the top address continues at address 0.
- DONE: d_ready = 1 until d_done is sampled; then go to IDLE.
- d_init while not in IDLE is ignored and pulses d_err for 1 cycle.
- d_done in SEEK or XFER aborts:
  - Go to IDLE next cycle with no further memory writes.
  - A beat handshaking in that same cycle is still completed.
  - d_ready is not asserted.
- d_init and d_done in the same IDLE cycle: d_init wins.
- Reset mid-burst returns to IDLE immediately. Storage contents written so far are retained.

Optional Feature:
Macro: DISK_PATTERN_INIT_EN.
- Defined: a read command (d_init with d_wr = 0) first fills the storage so that every word a becomes PAT_BASE + a, truncated to DATA_W. The fill is zero-time behavioural and happens at the command edge, before SEEK. Writes are never pattern-filled.
- Undefined: storage holds only what was written since simulation start; unwritten words read as X.

Test Plan:
- Reset, then idle for 10 cycles -> every output stays 0 and d_busy stays 0.
- With pattern enabled: read, d_addr = 5, d_len = 4, d_accept held high -> d_valid rises exactly 108 cycles after the d_init edge. Data is D15C0005, D15C0006, D15C0007, D15C0008 on consecutive cycles. d_ready is high the next cycle and drops one cycle after d_done.
- Write, d_addr = 1022, d_len = 4, data 11, 22, 33, 44, with d_wvalid toggling 1/0 -> exactly 4 writes, to addresses 1022, 1023, 0, 1 (wrap). A subsequent read of the same 4 words (pattern disabled) returns 11, 22, 33, 44.
- Read with d_accept stalled low for 5 cycles mid-burst -> d_data is held stable and no word is skipped or duplicated.
- d_len = 0, then a second d_init during SEEK -> d_err pulses for 1 cycle each time and the in-flight burst is unaffected.
- Abort: d_done asserted on the 2nd beat of an 8-word write -> exactly 2 words written, state returns to IDLE, d_ready never asserts. A new command is then accepted normally.
